membus_arb2: RTL
================

MEMBUS_ARB2 -- requirements
Module: membus_arb2

Interface
REQ-001 Parameter NXM_TIMEOUT, default 64: cycles without a response before a nonexistent-memory abort; legal range 2..255.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 a_rq_cyc, b_rq_cyc  input  1  requester A (CPU) / B (channel) wants a memory cycle.
REQ-005 a_rd_rq, b_rd_rq  input  1  cycle includes a read.
REQ-006 a_wr_rq, b_wr_rq  input  1  cycle includes a write.
REQ-007 a_ma, b_ma  input  18 [18:35]  memory address.
REQ-008 a_fmc_select, b_fmc_select  input  1  fast-memory select.
REQ-009 a_mb_out, b_mb_out  input  36 [0:35]  write data.
REQ-010 a_wr_rs, b_wr_rs  input  1  write-restart pulse (data valid).
REQ-011 a_addr_ack, b_addr_ack  output  1  address-acknowledge pulse to the requester.
REQ-012 a_rd_rs, b_rd_rs  output  1  read-restart pulse to the requester.
REQ-013 a_mb_in, b_mb_in  output  36  read data; zero unless that requester is in its read phase.
REQ-014 a_nxm, b_nxm  output  1  one-cycle nonexistent-memory abort pulse.
REQ-015 membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_fmc_select, membus_wr_rs  output  1  memory-side controls.
REQ-016 membus_ma  output  18  memory address; membus_mb_out  output  36  write data.
REQ-017 membus_addr_ack, membus_rd_rs  input  1  memory responses; membus_mb_in  input  36  read data.

Function
REQ-018 The FSM SHALL have the states IDLE, ADDR, RDATA and WDATA; exactly one requester is granted outside IDLE.
REQ-019 IDLE: when any rq_cyc is sampled high, the block SHALL latch the winner's ma, rd_rq, wr_rq and fmc_select and enter ADDR; membus_rq_cyc rises one cycle after the request.
REQ-020 Simultaneous requests: A wins (fixed priority), except as stated in REQ-031.
REQ-021 ADDR: membus_rq_cyc SHALL be 1 and the latched fields SHALL drive the memory side; on membus_addr_ack the block SHALL pass the pulse combinationally to the granted requester only, then go to WDATA if wr_rq is latched, else to RDATA.
REQ-022 ADDR: if the granted rq_cyc drops before addr_ack, the block SHALL return to IDLE without any response.
REQ-023 RDATA: membus_mb_in and membus_rd_rs SHALL be routed combinationally to the granted requester only; the block returns to IDLE the cycle after rd_rs.
REQ-024 WDATA: the granted requester's mb_out and wr_rs SHALL drive membus_mb_out and membus_wr_rs; the block returns to IDLE the cycle after wr_rs.
REQ-025 Ungranted requesters SHALL see addr_ack=0, rd_rs=0 and mb_in=0; outside WDATA, membus_mb_out SHALL be 0 (wired-OR bus).
REQ-026 A cycle counter SHALL reset on every state entry and count in ADDR and RDATA; on reaching NXM_TIMEOUT-1 the block SHALL pulse the granted requester's nxm and go to IDLE.
REQ-027 If a response and the timeout coincide, the response wins and nxm stays 0.
REQ-028 A back-to-back request is granted from IDLE, giving a minimum of one idle cycle between cycles.

Reset
REQ-029 While reset=0 the block SHALL be in IDLE, with the counter at 0, the latched fields at 0 and every output at 0, independent of clk.
REQ-030 Reset mid-cycle SHALL abandon the cycle silently, with no nxm pulse; the RR last-winner is set to B.

Configuration
REQ-031 With MEMBUS_ARB_RR_EN defined, simultaneous requests SHALL go to the requester that did not win the previous grant (round-robin); without it, A always wins.

Structure
REQ-032 Package membus_pkg SHALL hold the state enum, the MA width (18) and the MB width (36).
REQ-033 The timeout counter SHALL be the sub-module membus_nxm_timer, with inputs clear and enable and output expired.

Verification
REQ-034 A read, a_ma=18'o000026, memory returns 36'o145000_123456: a_addr_ack, then a_rd_rs with a_mb_in equal to that value; b_* outputs stay 0.
REQ-035 B write, mb_out=36'o777777777777: membus_wr_rs and membus_mb_out follow b_wr_rs; membus_mb_out=0 outside WDATA.
REQ-036 A and B request in the same cycle twice: A, A without MEMBUS_ARB_RR_EN; A, B with it.
REQ-037 No addr_ack for NXM_TIMEOUT=8: a_nxm is high exactly 8 cycles after ADDR entry; the next request is then granted.
REQ-038 reset=0 asserted in RDATA: outputs are 0 immediately; after release, an A read completes normally.

Source files
------------

// File: rtl/membus_pkg.sv
// Shared widths and FSM state encoding for the two-port memory bus arbiter (membus_arb2).
package membus_pkg;

   localparam int unsigned MA_W = 18;
   localparam int unsigned MB_W = 36;

   typedef logic [1:0] state_t;

   localparam state_t StIdle  = 2'd0;
   localparam state_t StAddr  = 2'd1;
   localparam state_t StRdata = 2'd2;
   localparam state_t StWdata = 2'd3;

endpackage

// File: rtl/membus_nxm_timer.sv
// Nonexistent-memory watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches Limit-1.
module membus_nxm_timer #(
   parameter int unsigned Limit = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LastCount = 8'(Limit - 1);

   logic [7:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = enable && (count_q == LastCount);

endmodule

// File: rtl/membus_arb2.sv
// Two-requester memory bus arbiter (A = CPU, B = channel) with nonexistent-memory timeout.
// Define MEMBUS_ARB_RR_EN for round-robin on simultaneous requests; otherwise A always wins.
module membus_arb2
   import membus_pkg::*;
#(
   parameter int unsigned NXM_TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            a_rq_cyc,
   input  logic            a_rd_rq,
   input  logic            a_wr_rq,
   input  logic [MA_W-1:0] a_ma,
   input  logic            a_fmc_select,
   input  logic [MB_W-1:0] a_mb_out,
   input  logic            a_wr_rs,
   output logic            a_addr_ack,
   output logic            a_rd_rs,
   output logic [MB_W-1:0] a_mb_in,
   output logic            a_nxm,
   input  logic            b_rq_cyc,
   input  logic            b_rd_rq,
   input  logic            b_wr_rq,
   input  logic [MA_W-1:0] b_ma,
   input  logic            b_fmc_select,
   input  logic [MB_W-1:0] b_mb_out,
   input  logic            b_wr_rs,
   output logic            b_addr_ack,
   output logic            b_rd_rs,
   output logic [MB_W-1:0] b_mb_in,
   output logic            b_nxm,
   output logic            membus_rq_cyc,
   output logic            membus_rd_rq,
   output logic            membus_wr_rq,
   output logic            membus_fmc_select,
   output logic            membus_wr_rs,
   output logic [MA_W-1:0] membus_ma,
   output logic [MB_W-1:0] membus_mb_out,
   input  logic            membus_addr_ack,
   input  logic            membus_rd_rs,
   input  logic [MB_W-1:0] membus_mb_in
);

   state_t          state_q, state_d;
   logic            gnt_b_q, gnt_b_d;
   logic [MA_W-1:0] ma_q, ma_d;
   logic            rd_q, rd_d, wr_q, wr_d, fmc_q, fmc_d;
   logic            a_nxm_q, a_nxm_d, b_nxm_q, b_nxm_d;
   logic            pick_b, gnt_rq_cyc, gnt_wr_rs, expired;
   logic            busy, in_addr, in_rdata, in_wdata;

`ifdef MEMBUS_ARB_RR_EN
   logic last_b_q;

   // Reset leaves B as last winner so the first tie goes to A.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_b_q <= 1'b1;
      end else if (state_q == StIdle && (a_rq_cyc || b_rq_cyc)) begin
         last_b_q <= pick_b;
      end
   end

   assign pick_b = b_rq_cyc && (!a_rq_cyc || !last_b_q);
`else
   assign pick_b = !a_rq_cyc;
`endif

   assign gnt_rq_cyc = gnt_b_q ? b_rq_cyc : a_rq_cyc;
   assign gnt_wr_rs  = gnt_b_q ? b_wr_rs : a_wr_rs;

   always_comb begin
      state_d = state_q;
      gnt_b_d = gnt_b_q;
      ma_d    = ma_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      fmc_d   = fmc_q;
      a_nxm_d = 1'b0;
      b_nxm_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (a_rq_cyc || b_rq_cyc) begin
               state_d = StAddr;
               gnt_b_d = pick_b;
               ma_d    = pick_b ? b_ma : a_ma;
               rd_d    = pick_b ? b_rd_rq : a_rd_rq;
               wr_d    = pick_b ? b_wr_rq : a_wr_rq;
               fmc_d   = pick_b ? b_fmc_select : a_fmc_select;
            end
         end
         StAddr: begin
            // A response in the timeout cycle still wins.
            if (membus_addr_ack) begin
               state_d = wr_q ? StWdata : StRdata;
            end else if (!gnt_rq_cyc) begin
               state_d = StIdle;
            end else if (expired) begin
               state_d = StIdle;
               a_nxm_d = !gnt_b_q;
               b_nxm_d = gnt_b_q;
            end
         end
         StRdata: begin
            if (membus_rd_rs) begin
               state_d = StIdle;
            end else if (expired) begin
               state_d = StIdle;
               a_nxm_d = !gnt_b_q;
               b_nxm_d = gnt_b_q;
            end
         end
         StWdata: begin
            if (gnt_wr_rs) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         gnt_b_q <= 1'b0;
         ma_q    <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         fmc_q   <= 1'b0;
         a_nxm_q <= 1'b0;
         b_nxm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_b_q <= gnt_b_d;
         ma_q    <= ma_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         fmc_q   <= fmc_d;
         a_nxm_q <= a_nxm_d;
         b_nxm_q <= b_nxm_d;
      end
   end

   membus_nxm_timer #(
      .Limit (NXM_TIMEOUT)
   ) u_nxm_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_d != state_q),
      .enable  (in_addr || in_rdata),
      .expired (expired)
   );

   assign busy     = (state_q != StIdle);
   assign in_addr  = (state_q == StAddr);
   assign in_rdata = (state_q == StRdata);
   assign in_wdata = (state_q == StWdata);

   assign a_addr_ack = in_addr && !gnt_b_q && membus_addr_ack;
   assign b_addr_ack = in_addr && gnt_b_q && membus_addr_ack;
   assign a_rd_rs    = in_rdata && !gnt_b_q && membus_rd_rs;
   assign b_rd_rs    = in_rdata && gnt_b_q && membus_rd_rs;
   assign a_mb_in    = (in_rdata && !gnt_b_q) ? membus_mb_in : '0;
   assign b_mb_in    = (in_rdata && gnt_b_q) ? membus_mb_in : '0;
   assign a_nxm      = a_nxm_q;
   assign b_nxm      = b_nxm_q;

   assign membus_rq_cyc     = in_addr;
   assign membus_ma         = busy ? ma_q : '0;
   assign membus_rd_rq      = busy && rd_q;
   assign membus_wr_rq      = busy && wr_q;
   assign membus_fmc_select = busy && fmc_q;
   // Wired-OR data bus: drive only while the write data phase is active.
   assign membus_mb_out     = in_wdata ? (gnt_b_q ? b_mb_out : a_mb_out) : '0;
   assign membus_wr_rs      = in_wdata && gnt_wr_rs;

endmodule
